// File: rtl/branch_resolve.sv
// Branch reservation station with in-order-by-age resolve and a
// three-state redirect strobe (IDLE -> PULSE -> GAP) toward fetch.
module branch_resolve #(
    parameter int ENTRIES = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             issueValid,
    output logic             issueReady,
    input  logic [31:0]      issuePc,
    input  logic [31:0]      issueImm,
    input  logic [2:0]       issueFunct3,
    input  logic [TAG_W-1:0] issueQj,
    input  logic [TAG_W-1:0] issueQk,
    input  logic [31:0]      issueVj,
    input  logic [31:0]      issueVk,
    input  logic             cdbValid,
    input  logic [TAG_W-1:0] cdbTag,
    input  logic [31:0]      cdbData,
    input  logic             flush,
    output logic             pcChange,
    output logic [31:0]      changeData,
    output logic             bneempty,
    output logic             nobranch
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(ENTRIES + 1);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

    state_t             r_state, w_state_nxt;
    logic [ENTRIES-1:0] r_busy;
    logic [31:0]        r_pc  [ENTRIES];
    logic [31:0]        r_imm [ENTRIES];
    logic [2:0]         r_f3  [ENTRIES];
    logic [TAG_W-1:0]   r_qj  [ENTRIES];
    logic [TAG_W-1:0]   r_qk  [ENTRIES];
    logic [31:0]        r_vj  [ENTRIES];
    logic [31:0]        r_vk  [ENTRIES];
    // Age = number of older busy entries; 0 is the oldest, unique among busy.
    logic [CNT_W-1:0]   r_age [ENTRIES];
    logic [31:0]        r_change;

    logic [ENTRIES-1:0] w_ready;
    logic               w_sel_valid;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [CNT_W-1:0]   w_sel_age;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic [CNT_W-1:0]   w_busy_cnt;
    logic               w_resolve;
    logic               w_taken;
    logic               w_issue;
    logic [CNT_W-1:0]   w_new_age;
    logic [TAG_W-1:0]   w_iqj, w_iqk;
    logic [31:0]        w_ivj, w_ivk;

    // Ready scan, oldest-ready pick, lowest free slot and occupancy count.
    always_comb begin
        w_ready      = '0;
        w_sel_valid  = 1'b0;
        w_sel_idx    = '0;
        w_sel_age    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_busy_cnt   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            w_ready[i] = r_busy[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
            w_busy_cnt = w_busy_cnt + CNT_W'(r_busy[i]);
            if (w_ready[i] && (!w_sel_valid || (r_age[i] < w_sel_age))) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_age   = r_age[i];
            end
            if (!r_busy[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    assign w_resolve = (r_state == S_IDLE) && w_sel_valid && !flush;
    assign w_taken   = ((r_f3[w_sel_idx] == 3'b000) && (r_vj[w_sel_idx] == r_vk[w_sel_idx])) ||
                       ((r_f3[w_sel_idx] == 3'b001) && (r_vj[w_sel_idx] != r_vk[w_sel_idx]));
    assign w_issue   = issueValid && w_free_found && !flush;
    assign w_new_age = w_busy_cnt - CNT_W'(w_resolve);

    assign w_iqj = (cdbValid && (issueQj != '0) && (cdbTag == issueQj)) ? '0 : issueQj;
    assign w_iqk = (cdbValid && (issueQk != '0) && (cdbTag == issueQk)) ? '0 : issueQk;
    assign w_ivj = (cdbValid && (issueQj != '0) && (cdbTag == issueQj)) ? cdbData : issueVj;
    assign w_ivk = (cdbValid && (issueQk != '0) && (cdbTag == issueQk)) ? cdbData : issueVk;

    // Entry storage: CDB wakeup, resolve retirement with age compaction, issue write.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_busy <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_pc[i]  <= '0;
                r_imm[i] <= '0;
                r_f3[i]  <= '0;
                r_qj[i]  <= '0;
                r_qk[i]  <= '0;
                r_vj[i]  <= '0;
                r_vk[i]  <= '0;
                r_age[i] <= '0;
            end
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (r_busy[i] && cdbValid && (cdbTag != '0)) begin
                    if (r_qj[i] == cdbTag) begin
                        r_vj[i] <= cdbData;
                        r_qj[i] <= '0;
                    end
                    if (r_qk[i] == cdbTag) begin
                        r_vk[i] <= cdbData;
                        r_qk[i] <= '0;
                    end
                end
                if (w_resolve && r_busy[i] && (r_age[i] > w_sel_age)) begin
                    r_age[i] <= r_age[i] - 1'b1;
                end
            end
            if (w_resolve) begin
                r_busy[w_sel_idx] <= 1'b0;
            end
            if (w_issue) begin
                r_busy[w_free_idx] <= 1'b1;
                r_pc[w_free_idx]   <= issuePc;
                r_imm[w_free_idx]  <= issueImm;
                r_f3[w_free_idx]   <= issueFunct3;
                r_qj[w_free_idx]   <= w_iqj;
                r_qk[w_free_idx]   <= w_iqk;
                r_vj[w_free_idx]   <= w_ivj;
                r_vk[w_free_idx]   <= w_ivk;
                r_age[w_free_idx]  <= w_new_age;
            end
        end
    end

    // Redirect FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Redirect FSM next state: a taken resolve launches a one-cycle pulse then a gap.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_resolve && w_taken) w_state_nxt = S_PULSE;
            S_PULSE: w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Redirect value is target - 4 since fetch adds 4 before the next fetch.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_change <= '0;
        end else if (w_resolve && w_taken) begin
            r_change <= r_pc[w_sel_idx] + r_imm[w_sel_idx] - 32'd4;
        end
    end

    assign pcChange   = (r_state == S_PULSE);
    assign changeData = r_change;
    assign issueReady = w_free_found;
    assign bneempty   = ~|r_busy;
    assign nobranch   = bneempty && (r_state == S_IDLE);

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: inputs driven and outputs sampled on the falling edge.
module tb_branch_resolve;

    logic        clock = 1'b0;
    logic        resetn;
    logic        issueValid;
    logic        issueReady;
    logic [31:0] issuePc, issueImm;
    logic [2:0]  issueFunct3;
    logic [3:0]  issueQj, issueQk;
    logic [31:0] issueVj, issueVk;
    logic        cdbValid;
    logic [3:0]  cdbTag;
    logic [31:0] cdbData;
    logic        flush;
    logic        pcChange;
    logic [31:0] changeData;
    logic        bneempty;
    logic        nobranch;

    int checks = 0;
    int errors = 0;

    branch_resolve #(.ENTRIES(2), .TAG_W(4)) dut (
        .clock(clock), .resetn(resetn),
        .issueValid(issueValid), .issueReady(issueReady),
        .issuePc(issuePc), .issueImm(issueImm), .issueFunct3(issueFunct3),
        .issueQj(issueQj), .issueQk(issueQk), .issueVj(issueVj), .issueVk(issueVk),
        .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
        .flush(flush), .pcChange(pcChange), .changeData(changeData),
        .bneempty(bneempty), .nobranch(nobranch)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_issue(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                             input logic [3:0] qj, input logic [31:0] vj,
                             input logic [3:0] qk, input logic [31:0] vk);
        issueValid = 1'b1; issuePc = pc; issueImm = imm; issueFunct3 = f3;
        issueQj = qj; issueVj = vj; issueQk = qk; issueVk = vk;
    endtask

    task automatic clear_inputs();
        issueValid = 1'b0; cdbValid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL rst_pc: pcChange=%0b want 0", pcChange); end
        checks++; if (changeData !== 32'h0) begin errors++; $display("FAIL rst_data: changeData=%h want 0", changeData); end
        checks++; if (bneempty !== 1'b1) begin errors++; $display("FAIL rst_empty: bneempty=%0b want 1", bneempty); end
        checks++; if (nobranch !== 1'b1) begin errors++; $display("FAIL rst_nobr: nobranch=%0b want 1", nobranch); end
        checks++; if (issueReady !== 1'b1) begin errors++; $display("FAIL rst_ready: issueReady=%0b want 1", issueReady); end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_taken_bne();
        set_issue(32'h100, 32'h20, 3'b001, 4'd0, 32'd5, 4'd0, 32'd7);
        step(); clear_inputs();
        checks++; if (bneempty !== 1'b0) begin errors++; $display("FAIL bne_busy: bneempty=%0b want 0", bneempty); end
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL bne_early: pcChange=%0b want 0", pcChange); end
        checks++; if (issueReady !== 1'b1) begin errors++; $display("FAIL bne_ready: issueReady=%0b want 1", issueReady); end
        step();
        checks++; if (pcChange !== 1'b1) begin errors++; $display("FAIL bne_pulse: pcChange=%0b want 1", pcChange); end
        checks++; if (changeData !== 32'h11C) begin errors++; $display("FAIL bne_data: changeData=%h want 0000011c", changeData); end
        checks++; if (nobranch !== 1'b0) begin errors++; $display("FAIL bne_nobr_p: nobranch=%0b want 0", nobranch); end
        step();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL bne_gap: pcChange=%0b want 0", pcChange); end
        checks++; if (changeData !== 32'h11C) begin errors++; $display("FAIL bne_hold: changeData=%h want 0000011c", changeData); end
        checks++; if (nobranch !== 1'b0) begin errors++; $display("FAIL bne_nobr_g: nobranch=%0b want 0", nobranch); end
        step();
        checks++; if (nobranch !== 1'b1) begin errors++; $display("FAIL bne_nobr_i: nobranch=%0b want 1", nobranch); end
    endtask

    task automatic test_not_taken();
        set_issue(32'h200, 32'h40, 3'b000, 4'd0, 32'd3, 4'd0, 32'd4);
        step(); clear_inputs();
        checks++; if (bneempty !== 1'b0) begin errors++; $display("FAIL nt_busy: bneempty=%0b want 0", bneempty); end
        step();
        checks++; if (bneempty !== 1'b1) begin errors++; $display("FAIL nt_empty: bneempty=%0b want 1", bneempty); end
        checks++; if (nobranch !== 1'b1) begin errors++; $display("FAIL nt_nobr: nobranch=%0b want 1", nobranch); end
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL nt_pc0: pcChange=%0b want 0", pcChange); end
        step();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL nt_pc1: pcChange=%0b want 0", pcChange); end
        checks++; if (changeData !== 32'h11C) begin errors++; $display("FAIL nt_data: changeData=%h want 0000011c", changeData); end
        // Unsupported funct3 with equal operands still resolves not-taken.
        set_issue(32'h240, 32'h8, 3'b100, 4'd0, 32'd8, 4'd0, 32'd8);
        step(); clear_inputs();
        step();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL f3_pc0: pcChange=%0b want 0", pcChange); end
        checks++; if (bneempty !== 1'b1) begin errors++; $display("FAIL f3_empty: bneempty=%0b want 1", bneempty); end
        step();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL f3_pc1: pcChange=%0b want 0", pcChange); end
    endtask

    task automatic test_cdb_wakeup();
        set_issue(32'hFFFFFFF0, 32'h20, 3'b000, 4'd3, 32'd0, 4'd0, 32'd9);
        step(); clear_inputs();
        cdbValid = 1'b1; cdbTag = 4'd2; cdbData = 32'd9;
        step(); clear_inputs();
        step();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL cdb_wait_pc: pcChange=%0b want 0", pcChange); end
        checks++; if (bneempty !== 1'b0) begin errors++; $display("FAIL cdb_wait_busy: bneempty=%0b want 0", bneempty); end
        cdbValid = 1'b1; cdbTag = 4'd3; cdbData = 32'd9;
        step(); clear_inputs();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL cdb_same: pcChange=%0b want 0", pcChange); end
        step();
        checks++; if (pcChange !== 1'b1) begin errors++; $display("FAIL cdb_pulse: pcChange=%0b want 1", pcChange); end
        checks++; if (changeData !== 32'h0000000C) begin errors++; $display("FAIL cdb_wrap: changeData=%h want 0000000c", changeData); end
        step(); step();
        checks++; if (nobranch !== 1'b1) begin errors++; $display("FAIL cdb_nobr: nobranch=%0b want 1", nobranch); end
    endtask

    task automatic test_same_cycle_capture();
        set_issue(32'h1000, 32'hFFFFFFF8, 3'b000, 4'd7, 32'd0, 4'd0, 32'h55);
        cdbValid = 1'b1; cdbTag = 4'd7; cdbData = 32'h55;
        step(); clear_inputs();
        step();
        checks++; if (pcChange !== 1'b1) begin errors++; $display("FAIL cap_pulse: pcChange=%0b want 1", pcChange); end
        checks++; if (changeData !== 32'h00000FF4) begin errors++; $display("FAIL cap_data: changeData=%h want 00000ff4", changeData); end
        step(); step();
    endtask

    task automatic test_back_to_back();
        set_issue(32'h200, 32'h40, 3'b001, 4'd0, 32'd1, 4'd0, 32'd2);
        step();
        set_issue(32'h300, 32'h10, 3'b000, 4'd0, 32'd6, 4'd0, 32'd6);
        step(); clear_inputs();
        checks++; if (pcChange !== 1'b1) begin errors++; $display("FAIL b2b_p1: pcChange=%0b want 1", pcChange); end
        checks++; if (changeData !== 32'h23C) begin errors++; $display("FAIL b2b_d1: changeData=%h want 0000023c", changeData); end
        step();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL b2b_gap: pcChange=%0b want 0", pcChange); end
        step();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL b2b_low: pcChange=%0b want 0", pcChange); end
        step();
        checks++; if (pcChange !== 1'b1) begin errors++; $display("FAIL b2b_p2: pcChange=%0b want 1", pcChange); end
        checks++; if (changeData !== 32'h30C) begin errors++; $display("FAIL b2b_d2: changeData=%h want 0000030c", changeData); end
        step();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL b2b_end: pcChange=%0b want 0", pcChange); end
        step();
        checks++; if (nobranch !== 1'b1) begin errors++; $display("FAIL b2b_nobr: nobranch=%0b want 1", nobranch); end
    endtask

    task automatic test_age_order();
        set_issue(32'h600, 32'h100, 3'b000, 4'd2, 32'd0, 4'd0, 32'd2);
        step();
        set_issue(32'h400, 32'h8, 3'b001, 4'd3, 32'd0, 4'd0, 32'd0);
        step(); clear_inputs();
        checks++; if (issueReady !== 1'b0) begin errors++; $display("FAIL age_full: issueReady=%0b want 0", issueReady); end
        cdbValid = 1'b1; cdbTag = 4'd2; cdbData = 32'd1;
        step(); clear_inputs();
        step();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL age_nt: pcChange=%0b want 0", pcChange); end
        checks++; if (issueReady !== 1'b1) begin errors++; $display("FAIL age_free: issueReady=%0b want 1", issueReady); end
        set_issue(32'h500, 32'h4, 3'b000, 4'd3, 32'd0, 4'd0, 32'h77);
        step(); clear_inputs();
        cdbValid = 1'b1; cdbTag = 4'd3; cdbData = 32'h77;
        step(); clear_inputs();
        step();
        checks++; if (pcChange !== 1'b1) begin errors++; $display("FAIL age_p1: pcChange=%0b want 1", pcChange); end
        checks++; if (changeData !== 32'h404) begin errors++; $display("FAIL age_d1: changeData=%h want 00000404", changeData); end
        step(); step(); step();
        checks++; if (pcChange !== 1'b1) begin errors++; $display("FAIL age_p2: pcChange=%0b want 1", pcChange); end
        checks++; if (changeData !== 32'h500) begin errors++; $display("FAIL age_d2: changeData=%h want 00000500", changeData); end
        step(); step();
        checks++; if (nobranch !== 1'b1) begin errors++; $display("FAIL age_nobr: nobranch=%0b want 1", nobranch); end
    endtask

    task automatic test_full_flush();
        set_issue(32'h700, 32'h10, 3'b001, 4'd5, 32'd0, 4'd0, 32'd1);
        step();
        set_issue(32'h710, 32'h10, 3'b001, 4'd5, 32'd0, 4'd0, 32'd1);
        step();
        checks++; if (issueReady !== 1'b0) begin errors++; $display("FAIL full_ready: issueReady=%0b want 0", issueReady); end
        set_issue(32'h800, 32'h40, 3'b001, 4'd0, 32'd1, 4'd0, 32'd2);
        step(); step(); clear_inputs();
        checks++; if (issueReady !== 1'b0) begin errors++; $display("FAIL full_ready2: issueReady=%0b want 0", issueReady); end
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL full_ovw0: pcChange=%0b want 0", pcChange); end
        step();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL full_ovw1: pcChange=%0b want 0", pcChange); end
        cdbValid = 1'b1; cdbTag = 4'd5; cdbData = 32'd9;
        step(); clear_inputs();
        step();
        checks++; if (pcChange !== 1'b1) begin errors++; $display("FAIL full_p: pcChange=%0b want 1", pcChange); end
        checks++; if (changeData !== 32'h70C) begin errors++; $display("FAIL full_d: changeData=%h want 0000070c", changeData); end
        flush = 1'b1;
        step(); clear_inputs();
        checks++; if (bneempty !== 1'b1) begin errors++; $display("FAIL fl_empty: bneempty=%0b want 1", bneempty); end
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL fl_gap: pcChange=%0b want 0", pcChange); end
        checks++; if (nobranch !== 1'b0) begin errors++; $display("FAIL fl_nobr_g: nobranch=%0b want 0", nobranch); end
        step();
        checks++; if (nobranch !== 1'b1) begin errors++; $display("FAIL fl_nobr: nobranch=%0b want 1", nobranch); end
        step(); step();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL fl_none: pcChange=%0b want 0", pcChange); end
        set_issue(32'h900, 32'h40, 3'b001, 4'd0, 32'd1, 4'd0, 32'd2);
        flush = 1'b1;
        step(); clear_inputs();
        checks++; if (bneempty !== 1'b1) begin errors++; $display("FAIL fl_iss: bneempty=%0b want 1", bneempty); end
        step();
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL fl_iss_pc: pcChange=%0b want 0", pcChange); end
    endtask

    task automatic test_reset_mid_pulse();
        set_issue(32'h100, 32'h20, 3'b001, 4'd0, 32'd5, 4'd0, 32'd7);
        step(); clear_inputs();
        step();
        checks++; if (pcChange !== 1'b1) begin errors++; $display("FAIL rmp_pulse: pcChange=%0b want 1", pcChange); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL rmp_pc: pcChange=%0b want 0", pcChange); end
        checks++; if (changeData !== 32'h0) begin errors++; $display("FAIL rmp_data: changeData=%h want 0", changeData); end
        checks++; if (nobranch !== 1'b1) begin errors++; $display("FAIL rmp_nobr: nobranch=%0b want 1", nobranch); end
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (pcChange !== 1'b0) begin errors++; $display("FAIL rmp_after%0d: pcChange=%0b want 0", k, pcChange); end
        end
    endtask

    task automatic test_release_issue();
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        set_issue(32'h100, 32'h20, 3'b001, 4'd0, 32'd5, 4'd0, 32'd7);
        step(); clear_inputs();
        checks++; if (bneempty !== 1'b0) begin errors++; $display("FAIL rel_accept: bneempty=%0b want 0", bneempty); end
        step();
        checks++; if (pcChange !== 1'b1) begin errors++; $display("FAIL rel_pulse: pcChange=%0b want 1", pcChange); end
        checks++; if (changeData !== 32'h11C) begin errors++; $display("FAIL rel_data: changeData=%h want 0000011c", changeData); end
        step(); step();
    endtask

    initial begin
        resetn = 1'b0;
        issueValid = 1'b0; issuePc = '0; issueImm = '0; issueFunct3 = '0;
        issueQj = '0; issueQk = '0; issueVj = '0; issueVk = '0;
        cdbValid = 1'b0; cdbTag = '0; cdbData = '0; flush = 1'b0;
        test_reset();
        test_taken_bne();
        test_not_taken();
        test_cdb_wakeup();
        test_same_cycle_capture();
        test_back_to_back();
        test_age_order();
        test_full_flush();
        test_reset_mid_pulse();
        test_release_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
